// File: rtl/alu_src_seq.sv
// Operand-source sequencer: registers ALU mux selects, tracks a stall-aware PC history and
// inserts a flush window after a redirect. Optional trap on illegal operand classes via
// ALU_SRC_SEQ_ILLEGAL_TRAP_EN.
module alu_src_seq #(
  parameter int unsigned REG_LEN      = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REG_LEN-1:0] pc,
  input  logic               dec_valid,
  input  logic [2:0]         dec_op,
  input  logic               stall,
  input  logic               redirect,
  output logic               alu1_sel,
  output logic [1:0]         alu2_sel,
  output logic [REG_LEN-1:0] ex_pc,
  output logic               ex_valid,
  output logic               flush,
  output logic               illegal
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [REG_LEN-1:0] pc_q1_q, pc_q1_d;
  logic [REG_LEN-1:0] ex_pc_q, ex_pc_d;
  logic               ex_valid_q, ex_valid_d;
  logic               sel1_q, sel1_d;
  logic [1:0]         sel2_q, sel2_d;

  logic               dec_sel1;
  logic [1:0]         dec_sel2;
  logic               dec_bad;
  logic               issue_valid;
  logic               do_issue;
  logic               do_bubble;

  always_comb begin
    dec_sel1 = 1'b0;
    dec_sel2 = 2'd0;
    case (dec_op)
      3'd1:    dec_sel2 = 2'd1;
      3'd2:    begin dec_sel1 = 1'b1; dec_sel2 = 2'd1; end
      3'd3:    begin dec_sel1 = 1'b1; dec_sel2 = 2'd2; end
      3'd4:    dec_sel2 = 2'd1;
      default: ;  // RR, BRANCH and (untrapped) classes 6/7 all use rs1/rs2
    endcase
  end

`ifdef ALU_SRC_SEQ_ILLEGAL_TRAP_EN
  assign dec_bad = dec_op[2] & dec_op[1];
`else
  assign dec_bad = 1'b0;
`endif

  assign issue_valid = dec_valid & ~dec_bad;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_q1_d    = pc_q1_q;
    ex_pc_d    = ex_pc_q;
    ex_valid_d = ex_valid_q;
    sel1_d     = sel1_q;
    sel2_d     = sel2_q;
    do_issue   = 1'b0;
    do_bubble  = 1'b0;

    case (state_q)
      StIdle: begin
        if (dec_valid) state_d = StRun;
        do_issue = ~stall;
      end
      StRun: begin
        // A redirect overrides a concurrent stall.
        if (redirect && ex_valid_q) begin
          state_d   = StFlush;
          cnt_d     = FlushLoad;
          do_bubble = 1'b1;
        end else begin
          do_issue = ~stall;
        end
      end
      StFlush: begin
        if (cnt_q == 3'd0) begin
          state_d  = StRun;
          do_issue = ~stall;
        end else begin
          cnt_d     = cnt_q - 3'd1;
          do_bubble = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_issue) begin
      pc_q1_d    = pc;
      ex_pc_d    = pc_q1_q;
      ex_valid_d = issue_valid;
      sel1_d     = issue_valid ? dec_sel1 : 1'b0;
      sel2_d     = issue_valid ? dec_sel2 : 2'd0;
    end else if (do_bubble) begin
      // PC history keeps moving so ex_pc lines up with the refilled pipe.
      pc_q1_d    = pc;
      ex_pc_d    = pc_q1_q;
      ex_valid_d = 1'b0;
      sel1_d     = 1'b0;
      sel2_d     = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      pc_q1_q    <= '0;
      ex_pc_q    <= '0;
      ex_valid_q <= 1'b0;
      sel1_q     <= 1'b0;
      sel2_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q1_q    <= pc_q1_d;
      ex_pc_q    <= ex_pc_d;
      ex_valid_q <= ex_valid_d;
      sel1_q     <= sel1_d;
      sel2_q     <= sel2_d;
    end
  end

`ifdef ALU_SRC_SEQ_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= do_issue & dec_valid & dec_bad;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign alu1_sel = sel1_q;
  assign alu2_sel = sel2_q;
  assign ex_pc    = ex_pc_q;
  assign ex_valid = ex_valid_q;
  assign flush    = (state_q == StFlush);

endmodule

// File: doc/alu_src_seq.md
# alu_src_seq

Operand-source sequencer for the execute-stage ALU. It decodes the operand class of each issued instruction into registered select lines for the ALU input multiplexers. It carries a stall-aware two-stage PC history so the execute stage always sees the PC of the instruction it is executing. On a taken jump or branch it inserts a fixed flush window and suppresses issue until the pipeline is refilled. It sits between decode and the ALU operand muxes and replaces free-running PC delay lines.

## Interface
- `REG_LEN`, 32: data and PC width.
- `FLUSH_CYCLES`, 2: bubble cycles inserted after a redirect. Legal range is 1..7.

- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pc` in `REG_LEN`: fetch-stage PC.
- `dec_valid` in 1: decode holds a valid instruction this cycle.
- `dec_op` in 3: operand class.
  - 0 = RR (rs1, rs2)
  - 1 = RI (rs1, imm)
  - 2 = AUIPC (pc, imm)
  - 3 = JAL (pc, const 4)
  - 4 = JALR (rs1, imm)
  - 5 = BRANCH (rs1, rs2)
  - 6 and 7 are illegal.
- `stall` in 1: hold all pipeline registers.
- `redirect` in 1: ALU reports a taken jump or branch. Only honoured when `ex_valid`=1.
- `alu1_sel` out 1: 0 = rs1, 1 = `ex_pc`.
- `alu2_sel` out 2: 0 = rs2, 1 = imm, 2 = const 4. Value 3 is never driven.
- `ex_pc` out `REG_LEN`: PC of the instruction currently in execute.
- `ex_valid` out 1: execute holds a real instruction.
- `flush` out 1: high while the flush window is active.
- `illegal` out 1: single-cycle pulse marking an illegal operand class.

## Operation
- FSM states: IDLE, RUN, FLUSH.
- IDLE is the reset state. The FSM moves to RUN on the first cycle with `dec_valid`=1.
- RUN, on each edge with `stall`=0:
  - `pc_q1` <= `pc`
  - `ex_pc` <= `pc_q1`
  - `ex_valid` <= `dec_valid`
  - `alu1_sel` and `alu2_sel` are decoded from `dec_op`, giving (sel1, sel2):
    - RR → (0, 0)
    - RI → (0, 1)
    - AUIPC → (1, 1)
    - JAL → (1, 2)
    - JALR → (0, 1)
    - BRANCH → (0, 0)
  - If `dec_valid`=0, both selects are 0.
- RUN with `stall`=1: every register holds, including the selects, `ex_pc` and `ex_valid`.
- RUN with `redirect`=1 and `ex_valid`=1:
  - The next state is FLUSH and the bubble counter loads `FLUSH_CYCLES`-1.
  - `ex_valid` becomes 0.
  - The selects are forced to (0, 0).
  - The PC registers keep shifting so that `ex_pc` tracks the refilled pipe.
- FLUSH, on every edge:
  - `ex_valid`=0 and the selects are (0, 0).
  - `flush`=1.
  - `stall` is ignored: the counter always decrements.
  - `redirect` is ignored.
  - When the counter reaches 0, the next state is RUN.
- Simultaneous events:
  - `redirect` together with `stall` → redirect wins.
  - `redirect` while `ex_valid`=0 → ignored.
- The counter width is 3 bits. It saturates at 0 and never wraps.

## Timing
- Reset value of every output and internal register is 0, and the FSM is in IDLE. Reset applies immediately on `rst_n` falling, including in the middle of a flush.
- Select latency: `dec_op` sampled at edge N appears on `alu1_sel` and `alu2_sel` after edge N. It is aligned with `ex_pc` and `ex_valid` for the same instruction.
- `ex_pc` equals `pc` as sampled two non-stalled edges earlier.
- `flush` rises on the edge after `redirect` is sampled and stays high for exactly `FLUSH_CYCLES` cycles.
- `ex_valid` is 0 throughout the flush window. It can return to 1 on the edge that exits FLUSH.
- `illegal` is registered and aligned with the `ex_valid` slot of the offending instruction.

## Configuration
- `ALU_SRC_SEQ_ILLEGAL_TRAP_EN` defined:
  - `dec_op` 6 or 7 with `dec_valid`=1 issues as a bubble: `ex_valid`=0 and selects (0, 0).
  - `illegal` pulses high for one cycle.
- Not defined:
  - `dec_op` 6 and 7 decode as RR and issue normally.
  - `illegal` is tied 0.

## Test plan
- Reset, then `dec_valid`=1, `dec_op`=3, with `pc`=0x100 two cycles earlier → `alu1_sel`=1, `alu2_sel`=2, `ex_pc`=0x100, `ex_valid`=1.
- Stream of RI, AUIPC, BRANCH with `pc` = 0x0, 0x4, 0x8 → selects (0,1), (1,1), (0,0) appear in that order, with `ex_pc` = 0x0, 0x4, 0x8.
- `stall`=1 for 3 cycles mid-stream → selects, `ex_pc` and `ex_valid` are frozen for 3 cycles, then resume with no lost or duplicated PC.
- `redirect`=1 with `ex_valid`=1 and `FLUSH_CYCLES`=2:
  - `flush`=1 for exactly 2 cycles and `ex_valid`=0 for both.
  - A second `redirect` during the flush is ignored.
  - A `stall` asserted during the flush does not extend the window.
- `rst_n` pulsed low during the flush → all outputs are 0 immediately and the FSM is in IDLE. The next `dec_valid` issues normally.
- `dec_op`=7 → with the macro: `illegal`=1 for 1 cycle and `ex_valid`=0. Without it: RR selects (0,0), `ex_valid`=1 and `illegal`=0.
